// File: rtl/buzzer_pkg.sv
// Shared types and constants for the melody sequencer.
// Half-period counts assume a 50 MHz clock.
package buzzer_pkg;

  typedef struct packed {
    logic [19:0] speed;
    logic [11:0] dur;
  } note_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    END  = 3'd4
  } state_t;

  localparam logic [19:0] NOTE_G4 = 20'd63776;
  localparam logic [19:0] NOTE_A4 = 20'd56818;
  localparam logic [19:0] NOTE_B4 = 20'd50619;
  localparam logic [19:0] NOTE_C5 = 20'd47778;
  localparam logic [19:0] NOTE_D5 = 20'd42566;
  localparam logic [19:0] NOTE_E5 = 20'd37921;
  localparam logic [19:0] REST    = 20'd0;

  localparam note_t DEFAULT_MELODY [8] = '{
    '{NOTE_C5, 12'd250},
    '{NOTE_E5, 12'd250},
    '{NOTE_D5, 12'd250},
    '{REST,    12'd125},
    '{NOTE_A4, 12'd250},
    '{NOTE_B4, 12'd250},
    '{NOTE_G4, 12'd500},
    '{REST,    12'd0}
  };

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing one tick every CLK_HZ/TICK_HZ
// cycles; clear restarts the count so a tick period begins cleanly.
module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if (DIV < 2) begin : g_bad_ratio
      $error("tick_gen: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || tick) cnt <= '0;
    else                        cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// Steps through a note table, driving the buzzer divider speed
// and enable, with a silent gap after every note or rest.
module buzzer_sequencer
  import buzzer_pkg::*;
#(
  parameter int    CLK_HZ    = 50_000_000,
  parameter int    TICK_HZ   = 1000,
  parameter int    GAP_TICKS = 20,
  parameter int    NUM_NOTES = 8,
  parameter note_t MELODY [NUM_NOTES] = DEFAULT_MELODY
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop,
  output logic [19:0]                  speed,
  output logic                         buzz_en,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_NOTES)-1:0] note_idx
);

  localparam int IW = $clog2(NUM_NOTES);

  state_t      state;
  state_t      nxt;
  note_t       cur;
  logic [19:0] spd_q;
  logic [19:0] spd_n;
  logic [11:0] cnt;
  logic        tick;
  logic        clear;
  logic        expire;
  logic        last;
  logic        wrap;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  assign cur    = MELODY[note_idx];
  assign last   = (note_idx == IW'(NUM_NOTES - 1));
  // A zero countdown (GAP_TICKS == 0) expires without waiting a tick.
  assign expire = (cnt == 12'd0) || (cnt == 12'd1 && tick);
  assign spd_n  = (state == LOAD) ? cur.speed : spd_q;
  assign wrap   = loop && ((state == LOAD && cur.dur == 12'd0) ||
                           (state == GAP && expire && last));

  always_comb begin
    nxt   = state;
    clear = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: begin
        clear = 1'b1;
        if (cur.dur == 12'd0) nxt = loop ? LOAD : END;
        else                  nxt = PLAY;
      end
      PLAY: if (expire) begin
        nxt   = GAP;
        clear = 1'b1;
      end
      GAP:  if (expire) nxt = (last && !loop) ? END : LOAD;
      END:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (stop) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      note_idx <= '0;
      cnt      <= '0;
      spd_q    <= '0;
      speed    <= '0;
      buzz_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= nxt;
      speed   <= (nxt == PLAY) ? spd_n : 20'd0;
      buzz_en <= (nxt == PLAY) && (spd_n != 20'd0);
      busy    <= (nxt == LOAD) || (nxt == PLAY) || (nxt == GAP);
      done    <= (nxt == END);

      if (state == LOAD) spd_q <= cur.speed;

      if (state == LOAD)                 cnt <= cur.dur;
      else if (state == PLAY && expire)  cnt <= 12'(GAP_TICKS);
      else if (tick && cnt != 12'd0)     cnt <= cnt - 12'd1;

      if (nxt == IDLE)                           note_idx <= '0;
      else if (wrap)                             note_idx <= '0;
      else if (state == GAP && expire && !last)  note_idx <= note_idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench: table vectors, directed sequences and random stop/reset/restart
// runs checked against a per-cycle timeline built from the note table.
module tb_buzzer_sequencer;
  import buzzer_pkg::*;

  localparam int P    = 10;
  localparam int GT   = 2;
  localparam int MAXC = 300;

  typedef struct packed {
    logic [19:0] sp;
    logic        bz;
    logic        by;
    logic        dn;
    logic [2:0]  ix;
  } out_t;

  typedef struct {
    int   sc;
    int   cyc;
    out_t e;
  } vec_t;

  localparam note_t MEL_A [8] = '{
    '{20'd500, 12'd3}, '{20'd0, 12'd2}, '{20'd250, 12'd1}, '{20'd0, 12'd0},
    '{20'd0, 12'd0}, '{20'd0, 12'd0}, '{20'd0, 12'd0}, '{20'd0, 12'd0}
  };
  localparam note_t MEL_B [8] = '{
    '{20'd100, 12'd1}, '{20'd100, 12'd1}, '{20'd100, 12'd1}, '{20'd100, 12'd1},
    '{20'd100, 12'd1}, '{20'd100, 12'd1}, '{20'd100, 12'd1}, '{20'd100, 12'd1}
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [19:0] sp_a, sp_b;
  logic        bz_a, bz_b, by_a, by_b, dn_a, dn_b;
  logic [2:0]  ix_a, ix_b;

  int checks = 0;
  int errors = 0;
  int shown  = 0;

  out_t base [0:MAXC];
  out_t tr_a [0:MAXC];
  out_t tr_b [0:MAXC];
  vec_t vt [$];

  always #5 clk = ~clk;

  buzzer_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(GT),
    .NUM_NOTES(8), .MELODY(MEL_A)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .speed(sp_a), .buzz_en(bz_a), .busy(by_a), .done(dn_a),
    .note_idx(ix_a)
  );

  buzzer_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(GT),
    .NUM_NOTES(8), .MELODY(MEL_B)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .speed(sp_b), .buzz_en(bz_b), .busy(by_b), .done(dn_b),
    .note_idx(ix_b)
  );

  function automatic void put(inout int c, input out_t o);
    if (c <= MAXC) base[c] = o;
    c++;
  endfunction

  // Expected outputs per cycle after a start sampled at edge 0 (cycle 1 = LOAD).
  function automatic void build(input note_t m [8], input bit lp);
    int c = 1;
    int i = 0;
    bit fin;
    int glen = (GT == 0) ? 1 : GT * P;
    for (int k = 0; k <= MAXC; k++) base[k] = '0;
    while (c <= MAXC) begin
      put(c, '{20'd0, 1'b0, 1'b1, 1'b0, 3'(i)});
      fin = 1'b0;
      if (m[i].dur == 12'd0) fin = 1'b1;
      else begin
        for (int t = 0; t < int'(m[i].dur) * P; t++)
          put(c, '{m[i].speed, m[i].speed != 0, 1'b1, 1'b0, 3'(i)});
        for (int t = 0; t < glen; t++)
          put(c, '{20'd0, 1'b0, 1'b1, 1'b0, 3'(i)});
        if (i == 7) fin = 1'b1;
        else i++;
      end
      if (fin) begin
        if (lp) i = 0;
        else begin
          put(c, '{20'd0, 1'b0, 1'b0, 1'b1, 3'(i)});
          break;
        end
      end
    end
  endfunction

  function automatic out_t smp_a();
    return '{sp_a, bz_a, by_a, dn_a, ix_a};
  endfunction

  function automatic out_t smp_b();
    return '{sp_b, bz_b, by_b, dn_b, ix_b};
  endfunction

  task automatic run(input bit lp, input int stop_at, input int rst_at,
                     input int st2, input bit collide, input int ncyc);
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = lp;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tr_a[0] = smp_a();
    tr_b[0] = smp_b();
    start = 1'b1;
    stop  = collide;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      tr_a[c] = smp_a();
      tr_b[c] = smp_b();
      start = (c == st2);
      stop  = (c == stop_at);
      reset = (c == rst_at);
    end
    start = 1'b0; stop = 1'b0; reset = 1'b0;
  endtask

  task automatic cmp(input string nm, input bit isb, input int cut,
                     input int rs, input int ncyc);
    out_t e, a;
    for (int c = 0; c <= ncyc; c++) begin
      if (c == 0)                e = '0;
      else if (c <= cut)         e = base[c];
      else if (rs > 0 && c > rs) e = base[c - rs];
      else                       e = '0;
      a = isb ? tr_b[c] : tr_a[c];
      checks++;
      if (a !== e) begin
        errors++;
        if (shown < 20)
          $display("FAIL %s cycle %0d: got spd=%0d bz=%b busy=%b done=%b idx=%0d, want spd=%0d bz=%b busy=%b done=%b idx=%0d",
                   nm, c, a.sp, a.bz, a.by, a.dn, a.ix, e.sp, e.bz, e.by, e.dn, e.ix);
        shown++;
      end
    end
  endtask

  task automatic vec(input int sc, input bit isb);
    out_t a;
    foreach (vt[k]) begin
      if (vt[k].sc == sc) begin
        a = isb ? tr_b[vt[k].cyc] : tr_a[vt[k].cyc];
        checks++;
        if (a !== vt[k].e) begin
          errors++;
          $display("FAIL vec sc%0d cycle %0d: got %h want %h",
                   sc, vt[k].cyc, a, vt[k].e);
        end
      end
    end
  endtask

  initial begin
    int s, r;
    bit lp, use_rst;

    vt.push_back('{0, 0,   '{20'd0,   1'b0, 1'b0, 1'b0, 3'd0}});
    vt.push_back('{0, 1,   '{20'd0,   1'b0, 1'b1, 1'b0, 3'd0}});
    vt.push_back('{0, 2,   '{20'd500, 1'b1, 1'b1, 1'b0, 3'd0}});
    vt.push_back('{0, 31,  '{20'd500, 1'b1, 1'b1, 1'b0, 3'd0}});
    vt.push_back('{0, 32,  '{20'd0,   1'b0, 1'b1, 1'b0, 3'd0}});
    vt.push_back('{0, 51,  '{20'd0,   1'b0, 1'b1, 1'b0, 3'd0}});
    vt.push_back('{0, 52,  '{20'd0,   1'b0, 1'b1, 1'b0, 3'd1}});
    vt.push_back('{0, 53,  '{20'd0,   1'b0, 1'b1, 1'b0, 3'd1}});
    vt.push_back('{0, 72,  '{20'd0,   1'b0, 1'b1, 1'b0, 3'd1}});
    vt.push_back('{0, 93,  '{20'd0,   1'b0, 1'b1, 1'b0, 3'd2}});
    vt.push_back('{0, 94,  '{20'd250, 1'b1, 1'b1, 1'b0, 3'd2}});
    vt.push_back('{0, 103, '{20'd250, 1'b1, 1'b1, 1'b0, 3'd2}});
    vt.push_back('{0, 104, '{20'd0,   1'b0, 1'b1, 1'b0, 3'd2}});
    vt.push_back('{0, 124, '{20'd0,   1'b0, 1'b1, 1'b0, 3'd3}});
    vt.push_back('{0, 125, '{20'd0,   1'b0, 1'b0, 1'b1, 3'd3}});
    vt.push_back('{0, 126, '{20'd0,   1'b0, 1'b0, 1'b0, 3'd0}});
    vt.push_back('{1, 124, '{20'd0,   1'b0, 1'b1, 1'b0, 3'd3}});
    vt.push_back('{1, 125, '{20'd0,   1'b0, 1'b1, 1'b0, 3'd0}});
    vt.push_back('{1, 126, '{20'd500, 1'b1, 1'b1, 1'b0, 3'd0}});
    vt.push_back('{2, 217, '{20'd0,   1'b0, 1'b1, 1'b0, 3'd6}});
    vt.push_back('{2, 218, '{20'd0,   1'b0, 1'b1, 1'b0, 3'd7}});
    vt.push_back('{2, 219, '{20'd100, 1'b1, 1'b1, 1'b0, 3'd7}});
    vt.push_back('{2, 248, '{20'd0,   1'b0, 1'b1, 1'b0, 3'd7}});
    vt.push_back('{2, 249, '{20'd0,   1'b0, 1'b0, 1'b1, 3'd7}});
    vt.push_back('{2, 250, '{20'd0,   1'b0, 1'b0, 1'b0, 3'd0}});

    // basic play
    build(MEL_A, 1'b0);
    run(1'b0, 0, 0, 0, 1'b0, 140);
    vec(0, 1'b0);
    cmp("basic", 1'b0, 140, 0, 140);

    // loop
    build(MEL_A, 1'b1);
    run(1'b1, 0, 0, 0, 1'b0, 180);
    vec(1, 1'b0);
    cmp("loop", 1'b0, 180, 0, 180);

    // stop mid-note
    build(MEL_A, 1'b0);
    run(1'b0, 15, 0, 0, 1'b0, 60);
    cmp("stop", 1'b0, 15, 0, 60);

    // reset mid-gap then restart
    run(1'b0, 0, 40, 45, 1'b0, 100);
    cmp("reset_gap", 1'b0, 40, 45, 100);

    // start and stop together in idle
    run(1'b0, 0, 0, 0, 1'b1, 20);
    cmp("collide", 1'b0, 0, 0, 20);

    // start while busy is ignored
    run(1'b0, 0, 0, 20, 1'b0, 140);
    cmp("restart_busy", 1'b0, 140, 0, 140);

    // full table, no end marker
    build(MEL_B, 1'b0);
    run(1'b0, 0, 0, 0, 1'b0, 260);
    vec(2, 1'b1);
    cmp("full_table", 1'b1, 260, 0, 260);

    // random stop/reset points and restarts
    for (int it = 0; it < 12; it++) begin
      lp      = 1'($urandom % 2);
      use_rst = 1'($urandom % 2);
      s       = $urandom_range(2, 140);
      r       = s + $urandom_range(1, 30);
      build(MEL_A, lp);
      if (use_rst) run(lp, 0, s, r, 1'b0, 200);
      else         run(lp, s, 0, r, 1'b0, 200);
      cmp($sformatf("rand%0d", it), 1'b0, s, r, 200);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
